// File: rtl/debug_rx_word_assembler.sv
// Packs the debug UART byte stream into big-endian 32-bit command words with a one-cycle valid pulse.
// Define DEBUG_RX_TIMEOUT_EN to add the inter-byte timeout that discards partial words.
module debug_rx_word_assembler #(
  parameter int                    NB_BITS        = 32,
  parameter int                    NB_BYTE        = 8,
  parameter int                    NB_TIMER       = 24,
  parameter logic [NB_TIMER-1:0]   TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_BITS-1:0] o_inst,
  output logic               o_valid,
  output logic [1:0]         o_byte_cnt,
  output logic               o_timeout
);

  localparam int NB_KEEP = NB_BITS - NB_BYTE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DONE
  } state_t;

  if (NB_BITS != 4 * NB_BYTE || TIMEOUT_CYCLES == '0) begin : g_bad_cfg
    $error("debug_rx_word_assembler: NB_BITS must be 4*NB_BYTE and TIMEOUT_CYCLES nonzero");
  end

  state_t             r_state;
  logic [NB_KEEP-1:0] r_shift;
  logic [1:0]         r_cnt;

  // The three held bytes plus the incoming one form the finished word.
  wire [NB_BITS-1:0] w_next_word  = {r_shift, i_rx_data};
  wire [NB_KEEP-1:0] w_next_shift = {r_shift[NB_KEEP-NB_BYTE-1:0], i_rx_data};

`ifdef DEBUG_RX_TIMEOUT_EN
  logic [NB_TIMER-1:0] r_timer;
  // An arriving byte always beats expiry on the same edge.
  wire w_expired = (r_state == ST_RECV) && !i_rx_done &&
                   (r_timer == TIMEOUT_CYCLES - 1'b1);
`endif

  // NOTE: all state, including the shift register, is cleared by the synchronous
  // reset, and every assignment here is non-blocking so the edge sees old values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      o_inst  <= '0;
      o_valid <= 1'b0;
`ifdef DEBUG_RX_TIMEOUT_EN
      r_timer   <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
`ifdef DEBUG_RX_TIMEOUT_EN
      o_timeout <= 1'b0;
      if (r_state == ST_RECV && !i_rx_done && !w_expired) r_timer <= r_timer + 1'b1;
      else                                               r_timer <= '0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_rx_done) begin
            r_shift <= w_next_shift;
            r_cnt   <= 2'd1;
            r_state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (i_rx_done) begin
            if (r_cnt == 2'd3) begin
              o_inst  <= w_next_word;
              o_valid <= 1'b1;
              r_shift <= '0;
              r_cnt   <= 2'd0;
              r_state <= ST_DONE;
            end else begin
              r_shift <= w_next_shift;
              r_cnt   <= r_cnt + 2'd1;
            end
          end
`ifdef DEBUG_RX_TIMEOUT_EN
          else if (w_expired) begin
            r_shift   <= '0;
            r_cnt     <= 2'd0;
            o_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end
`endif
        end
        ST_DONE: begin
          // A byte landing in the valid cycle starts the next word immediately.
          if (i_rx_done) begin
            r_shift <= w_next_shift;
            r_cnt   <= 2'd1;
            r_state <= ST_RECV;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifndef DEBUG_RX_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

  assign o_byte_cnt = r_cnt;

endmodule
